// File: rtl/mode_controller.sv
// mode_controller: front-panel mode sequencer for the clock design.
// Turns three debounced button levels into the display/edit mode, single-cycle
// increment strobes for the clock and alarm registers, stopwatch run/clear
// controls, and a digit blink mask for the field being edited.
// Optional feature macro: MODE_TIMEOUT_EN builds the edit-mode inactivity
// timeout (TIMEOUT_S ticks of tick_1hz) that returns the block to CLOCK.
module mode_controller #(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_adj,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    output logic [1:0] mode,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       clk_inc_hr,
    output logic       clk_inc_min,
    output logic       alm_inc_hr,
    output logic       alm_inc_min,
    output logic [3:0] blink_mask
);

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'b00,
        MODE_SW    = 2'b01,
        MODE_CSET  = 2'b10,
        MODE_ASET  = 2'b11
    } mode_t;

    // Button history flops reset to 1 so a button held through reset is not an event
    logic  btn_mode_q, btn_set_q, btn_adj_q;
    mode_t mode_q, mode_d, mode_nxt;
    logic  edit_sel_q, edit_sel_d;   // 0 = hours, 1 = minutes
    logic  phase_q, phase_d;         // blink phase, 1 = selected digits blanked
    logic  sw_run_q, sw_run_d;
    logic  sw_clear_q, sw_clear_d;
    logic  [3:0] inc_q, inc_d;       // {clk_hr, clk_min, alm_hr, alm_min}
    logic  mode_ev, set_ev, adj_ev, any_ev, in_set;

`ifdef MODE_TIMEOUT_EN
    localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_S - 1);
    logic [7:0] tout_cnt_q, tout_cnt_d;
`else
    // Timeout not built: tick_1hz and TIMEOUT_S deliberately have no effect
    logic unused_tick;
    assign unused_tick = tick_1hz ^ (TIMEOUT_S == 0);
`endif

    assign mode_ev  = btn_mode & ~btn_mode_q;
    assign set_ev   = btn_set  & ~btn_set_q;
    assign adj_ev   = btn_adj  & ~btn_adj_q;
    assign any_ev   = mode_ev | set_ev | adj_ev;
    assign in_set   = mode_q[1];
    assign mode_nxt = mode_t'(mode_q + 2'd1);

    // State register: all flops, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_mode_q <= 1'b1;
            btn_set_q  <= 1'b1;
            btn_adj_q  <= 1'b1;
            mode_q     <= MODE_CLOCK;
            edit_sel_q <= 1'b0;
            phase_q    <= 1'b0;
            sw_run_q   <= 1'b0;
            sw_clear_q <= 1'b0;
            inc_q      <= 4'b0000;
`ifdef MODE_TIMEOUT_EN
            tout_cnt_q <= 8'd0;
`endif
        end else begin
            btn_mode_q <= btn_mode;
            btn_set_q  <= btn_set;
            btn_adj_q  <= btn_adj;
            mode_q     <= mode_d;
            edit_sel_q <= edit_sel_d;
            phase_q    <= phase_d;
            sw_run_q   <= sw_run_d;
            sw_clear_q <= sw_clear_d;
            inc_q      <= inc_d;
`ifdef MODE_TIMEOUT_EN
            tout_cnt_q <= tout_cnt_d;
`endif
        end
    end

    // Next-state logic: mode stepping has priority over set/adj in the same cycle
    always_comb begin
        mode_d     = mode_q;
        edit_sel_d = edit_sel_q;
        sw_run_d   = sw_run_q;
        sw_clear_d = 1'b0;
        inc_d      = 4'b0000;
        phase_d    = phase_q ^ tick_2hz;
        if (mode_ev) begin
            mode_d = mode_nxt;
            if (mode_nxt[1]) begin
                edit_sel_d = 1'b0;
                phase_d    = 1'b0;
            end
        end else begin
            case (mode_q)
                MODE_SW: begin
                    if (set_ev) sw_run_d = ~sw_run_q;
                    if (adj_ev && !sw_run_q) sw_clear_d = 1'b1;
                end
                MODE_CSET, MODE_ASET: begin
                    if (set_ev) edit_sel_d = ~edit_sel_q;
                    if (adj_ev) begin
                        if (mode_q == MODE_CSET) inc_d = edit_sel_q ? 4'b0100 : 4'b1000;
                        else                     inc_d = edit_sel_q ? 4'b0001 : 4'b0010;
                    end
                    // Keep digits visible right after the user touches them
                    if (set_ev || adj_ev) phase_d = 1'b0;
                end
                default: ;
            endcase
        end
`ifdef MODE_TIMEOUT_EN
        tout_cnt_d = tout_cnt_q;
        if (any_ev || !in_set) begin
            tout_cnt_d = 8'd0;
        end else if (tick_1hz) begin
            if (tout_cnt_q == TOUT_LAST) begin
                mode_d     = MODE_CLOCK;
                edit_sel_d = 1'b0;
                tout_cnt_d = 8'd0;
            end else begin
                tout_cnt_d = tout_cnt_q + 8'd1;
            end
        end
`endif
    end

    // Output logic: blank the selected field during the blink-off phase of set modes
    always_comb begin
        blink_mask = 4'b0000;
        if (in_set && phase_q) blink_mask = edit_sel_q ? 4'b0011 : 4'b1100;
    end

    assign mode        = mode_q;
    assign sw_run      = sw_run_q;
    assign sw_clear    = sw_clear_q;
    assign clk_inc_hr  = inc_q[3];
    assign clk_inc_min = inc_q[2];
    assign alm_inc_hr  = inc_q[1];
    assign alm_inc_min = inc_q[0];

endmodule

// File: tb/tb_mode_controller.sv
// tb_mode_controller: scoreboard bench for mode_controller.
// Stimulus pushes the hand-computed output vector expected after each clock
// edge; a monitor pops and compares on the following falling edge.
// Vector layout: {mode[1:0], sw_run, sw_clear, clk_hr, clk_min, alm_hr, alm_min, blink_mask[3:0]}
module tb_mode_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b1, btn_set = 1'b0, btn_adj = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
    logic [1:0] mode;
    logic       sw_run, sw_clear, clk_inc_hr, clk_inc_min, alm_inc_hr, alm_inc_min;
    logic [3:0] blink_mask;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int         cyc_q[$];
    logic [11:0] vec_q[$];
    string      nm_q[$];

    mode_controller #(.TIMEOUT_S(3)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_adj(btn_adj),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .mode(mode), .sw_run(sw_run), .sw_clear(sw_clear),
        .clk_inc_hr(clk_inc_hr), .clk_inc_min(clk_inc_min),
        .alm_inc_hr(alm_inc_hr), .alm_inc_min(alm_inc_min),
        .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] out_vec();
        return {mode, sw_run, sw_clear, clk_inc_hr, clk_inc_min,
                alm_inc_hr, alm_inc_min, blink_mask};
    endfunction

    task automatic check(input string nm, input logic [11:0] e);
        logic [11:0] got;
        got = out_vec();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, got, e);
        end else begin
            $display("ok   %s: %b", nm, got);
        end
    endtask

    // Monitor: compare every expectation scheduled for this cycle
    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            check(nm_q[0], vec_q[0]);
            void'(cyc_q.pop_front());
            void'(vec_q.pop_front());
            void'(nm_q.pop_front());
        end
    end

    // Drive buttons {mode,set,adj} and ticks {1hz,2hz} for one edge; queue the result
    task automatic step(input logic [2:0] b, input logic [1:0] t,
                        input logic [11:0] e, input string nm);
        @(negedge clk);
        btn_mode = b[2]; btn_set = b[1]; btn_adj = b[0];
        tick_1hz = t[1]; tick_2hz = t[0];
        cyc_q.push_back(cyc + 1);
        vec_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        // Reset with btn_mode held, then release: no mode event
        step(3'b100, 2'b00, 12'b00_0_0_0000_0000, "reset_state");
        rst = 1'b0;
        step(3'b100, 2'b00, 12'b00_0_0_0000_0000, "rst_hold");
        step(3'b000, 2'b00, 12'b00_0_0_0000_0000, "rst_release");

        // Mode stepping
        step(3'b100, 2'b00, 12'b01_0_0_0000_0000, "mode_to_sw");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "mode_sw_hold");
        step(3'b100, 2'b00, 12'b10_0_0_0000_0000, "mode_to_cset");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "mode_cset_hold");
        step(3'b100, 2'b00, 12'b11_0_0_0000_0000, "mode_to_aset");
        step(3'b000, 2'b00, 12'b11_0_0_0000_0000, "mode_aset_hold");
        step(3'b100, 2'b00, 12'b00_0_0_0000_0000, "mode_to_clock");
        step(3'b000, 2'b00, 12'b00_0_0_0000_0000, "mode_clock_hold");

        // Stopwatch
        step(3'b100, 2'b00, 12'b01_0_0_0000_0000, "sw_enter");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "sw_idle");
        step(3'b010, 2'b00, 12'b01_1_0_0000_0000, "sw_start");
        step(3'b000, 2'b00, 12'b01_1_0_0000_0000, "sw_running");
        step(3'b001, 2'b00, 12'b01_1_0_0000_0000, "sw_clear_ignored");
        step(3'b000, 2'b00, 12'b01_1_0_0000_0000, "sw_running2");
        step(3'b010, 2'b00, 12'b01_0_0_0000_0000, "sw_stop");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "sw_stopped");
        step(3'b001, 2'b00, 12'b01_0_1_0000_0000, "sw_clear_pulse");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "sw_clear_end");
        step(3'b010, 2'b00, 12'b01_1_0_0000_0000, "sw_restart");
        step(3'b000, 2'b00, 12'b01_1_0_0000_0000, "sw_restart_rel");
        step(3'b100, 2'b00, 12'b10_1_0_0000_0000, "sw_bg_cset");
        step(3'b000, 2'b00, 12'b10_1_0_0000_0000, "sw_bg_cset_rel");
        step(3'b100, 2'b00, 12'b11_1_0_0000_0000, "sw_bg_aset");
        step(3'b000, 2'b00, 12'b11_1_0_0000_0000, "sw_bg_aset_rel");
        step(3'b100, 2'b00, 12'b00_1_0_0000_0000, "sw_bg_clock");
        step(3'b000, 2'b00, 12'b00_1_0_0000_0000, "sw_bg_clock_rel");
        // CLOCK ignores set/adj
        step(3'b010, 2'b00, 12'b00_1_0_0000_0000, "clock_set_ignored");
        step(3'b000, 2'b00, 12'b00_1_0_0000_0000, "clock_set_rel");
        step(3'b001, 2'b00, 12'b00_1_0_0000_0000, "clock_adj_ignored");
        step(3'b000, 2'b00, 12'b00_1_0_0000_0000, "clock_adj_rel");
        step(3'b100, 2'b00, 12'b01_1_0_0000_0000, "sw_reenter");
        step(3'b000, 2'b00, 12'b01_1_0_0000_0000, "sw_reenter_rel");
        step(3'b010, 2'b00, 12'b01_0_0_0000_0000, "sw_stop2");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "sw_stop2_rel");

        // CLOCK_SET strobes
        step(3'b100, 2'b00, 12'b10_0_0_0000_0000, "cset_enter");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "cset_enter_rel");
        step(3'b001, 2'b00, 12'b10_0_0_1000_0000, "clk_inc_hr");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "clk_inc_hr_end");
        step(3'b010, 2'b00, 12'b10_0_0_0000_0000, "cset_sel_min");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "cset_sel_rel");
        step(3'b001, 2'b00, 12'b10_0_0_0100_0000, "clk_inc_min");
        for (int i = 0; i < 99; i++)
            step(3'b001, 2'b00, 12'b10_0_0_0000_0000, "adj_held");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "adj_released");

        // Simultaneous mode+adj: mode wins, no strobe
        step(3'b101, 2'b00, 12'b11_0_0_0000_0000, "simul_mode_adj");
        step(3'b000, 2'b00, 12'b11_0_0_0000_0000, "simul_rel");

        // ALARM_SET blink and strobes
        step(3'b000, 2'b01, 12'b11_0_0_0000_1100, "blink_hr_on");
        step(3'b000, 2'b00, 12'b11_0_0_0000_1100, "blink_hr_stay");
        step(3'b000, 2'b01, 12'b11_0_0_0000_0000, "blink_hr_off");
        step(3'b010, 2'b00, 12'b11_0_0_0000_0000, "aset_sel_min");
        step(3'b000, 2'b00, 12'b11_0_0_0000_0000, "aset_sel_rel");
        step(3'b000, 2'b01, 12'b11_0_0_0000_0011, "blink_min_on");
        step(3'b001, 2'b01, 12'b11_0_0_0001_0000, "alm_inc_min_vs_tick");
        step(3'b000, 2'b00, 12'b11_0_0_0000_0000, "alm_inc_min_end");
        step(3'b000, 2'b01, 12'b11_0_0_0000_0011, "blink_min_on2");
        step(3'b010, 2'b00, 12'b11_0_0_0000_0000, "aset_sel_hr");
        step(3'b000, 2'b00, 12'b11_0_0_0000_0000, "aset_sel_hr_rel");
        step(3'b001, 2'b00, 12'b11_0_0_0010_0000, "alm_inc_hr");
        step(3'b000, 2'b00, 12'b11_0_0_0000_0000, "alm_inc_hr_end");
        step(3'b100, 2'b00, 12'b00_0_0_0000_0000, "aset_to_clock");
        step(3'b000, 2'b00, 12'b00_0_0_0000_0000, "aset_to_clock_rel");

        // Timeout behaviour
        step(3'b100, 2'b00, 12'b01_0_0_0000_0000, "to_sw");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "to_sw_rel");
        step(3'b100, 2'b00, 12'b10_0_0_0000_0000, "to_cset");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "to_cset_rel");
`ifdef MODE_TIMEOUT_EN
        step(3'b000, 2'b10, 12'b10_0_0_0000_0000, "tout_tick1");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout_gap1");
        step(3'b000, 2'b10, 12'b10_0_0_0000_0000, "tout_tick2");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout_gap2");
        step(3'b000, 2'b10, 12'b00_0_0_0000_0000, "tout_expire");
        step(3'b000, 2'b00, 12'b00_0_0_0000_0000, "tout_clock");
        step(3'b100, 2'b00, 12'b01_0_0_0000_0000, "tout2_sw");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "tout2_sw_rel");
        step(3'b100, 2'b00, 12'b10_0_0_0000_0000, "tout2_cset");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout2_cset_rel");
        step(3'b000, 2'b10, 12'b10_0_0_0000_0000, "tout2_tick1");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout2_gap1");
        step(3'b000, 2'b10, 12'b10_0_0_0000_0000, "tout2_tick2");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout2_gap2");
        step(3'b001, 2'b10, 12'b10_0_0_1000_0000, "tout2_adj_wins");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout2_adj_rel");
        step(3'b000, 2'b10, 12'b10_0_0_0000_0000, "tout2_tick_a");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout2_gap_a");
        step(3'b000, 2'b10, 12'b10_0_0_0000_0000, "tout2_tick_b");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "tout2_gap_b");
        step(3'b000, 2'b10, 12'b00_0_0_0000_0000, "tout2_expire");
        step(3'b000, 2'b00, 12'b00_0_0_0000_0000, "tout2_clock");
`else
        for (int i = 0; i < 5; i++) begin
            step(3'b000, 2'b10, 12'b10_0_0_0000_0000, "no_tout_tick");
            step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "no_tout_gap");
        end
        step(3'b100, 2'b00, 12'b11_0_0_0000_0000, "no_tout_aset");
        step(3'b000, 2'b00, 12'b11_0_0_0000_0000, "no_tout_aset_rel");
        step(3'b100, 2'b00, 12'b00_0_0_0000_0000, "no_tout_clock");
        step(3'b000, 2'b00, 12'b00_0_0_0000_0000, "no_tout_clock_rel");
`endif

        // Asynchronous reset clears an in-flight strobe mid-cycle
        step(3'b100, 2'b00, 12'b01_0_0_0000_0000, "ar_sw");
        step(3'b000, 2'b00, 12'b01_0_0_0000_0000, "ar_sw_rel");
        step(3'b100, 2'b00, 12'b10_0_0_0000_0000, "ar_cset");
        step(3'b000, 2'b00, 12'b10_0_0_0000_0000, "ar_cset_rel");
        step(3'b001, 2'b00, 12'b10_0_0_1000_0000, "ar_strobe");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", 12'b00_0_0_0000_0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(3'b001, 2'b00, 12'b00_0_0_0000_0000, "post_rst_adj_held");
        step(3'b000, 2'b00, 12'b00_0_0_0000_0000, "post_rst_idle");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && cyc_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (cyc_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", cyc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
